// File: rtl/mult_sequencer.sv
// Control sequencer for the 8-bit shift-add multiplier datapath.
// Turns a level run request into clear + WIDTH add/shift iterations, then a done pulse.
module mult_sequencer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          clear_load,
    input  logic          m,
    output logic          ld_b,
    output logic          clr_xa,
    output logic          ld_xa,
    output logic          sub,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADD,
        S_SHIFT,
        S_FIN,
        S_HOLD
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        r_state;
    logic [CW-1:0] r_iter;
    logic          w_last;

    assign w_last = (r_iter == LAST);
    assign iter   = r_iter;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // clear_load wins over run in the same cycle
                    if (!clear_load && run) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_ADD;
                    r_iter  <= '0;
                end
                S_ADD: begin
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_state <= S_FIN;
                        r_iter  <= '0;
                    end else begin
                        r_state <= S_ADD;
                        r_iter  <= r_iter + CW'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    // run must be released before another multiplication starts
                    if (!run) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_iter  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ld_b   = 1'b0;
        clr_xa = 1'b0;
        ld_xa  = 1'b0;
        sub    = 1'b0;
        shift  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE:  ld_b = clear_load;
            S_START: begin
                clr_xa = 1'b1;
                busy   = 1'b1;
            end
            S_ADD: begin
                ld_xa = m;
                sub   = m & w_last;
                busy  = 1'b1;
            end
            S_SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

endmodule
